// File: rtl/mips_pkg.sv
// mips_pkg: shared instruction-kind enum, opcode and funct constants, and
// field-packing helpers. The main control decoder uses the same constants,
// so encoder and decoder cannot drift apart.
package mips_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_BNE  = 4'd8,
    K_ADDI = 4'd9,
    K_J    = 4'd10,
    K_LB   = 4'd11
  } instr_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LB    = 6'h20;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer turning an instruction kind plus fields
// into a 32-bit MIPS machine word. Fields not used by a format are dropped.
// Build option: MIPS_LB_EN makes kind LB legal (opcode 0x20); without it
// LB is reported illegal like kinds 12-15.
// Ports:
//   kind   in  4   instruction kind (instr_kind_t encoding)
//   rs/rt/rd in 5  register fields
//   imm    in  16  I-type immediate
//   target in  26  J-type target
//   word   out 32  packed machine word (0 when illegal)
//   legal  out 1   kind is encodable in this build
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (kind)
      K_ADD:  word = enc_r(rs, rt, rd, FUNCT_ADD);
      K_SUB:  word = enc_r(rs, rt, rd, FUNCT_SUB);
      K_AND:  word = enc_r(rs, rt, rd, FUNCT_AND);
      K_OR:   word = enc_r(rs, rt, rd, FUNCT_OR);
      K_SLT:  word = enc_r(rs, rt, rd, FUNCT_SLT);
      K_LW:   word = enc_i(OP_LW, rs, rt, imm);
      K_SW:   word = enc_i(OP_SW, rs, rt, imm);
      K_BEQ:  word = enc_i(OP_BEQ, rs, rt, imm);
      K_BNE:  word = enc_i(OP_BNE, rs, rt, imm);
      K_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
      K_J:    word = enc_j(OP_J, target);
`ifdef MIPS_LB_EN
      K_LB:   word = enc_i(OP_LB, rs, rt, imm);
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: program loader. Accepts symbolic instruction requests over
// valid/ready, packs them via instr_pack and writes them sequentially into
// instruction memory with one cycle of latency.
// Build option: MIPS_LB_EN (see instr_pack) enables the LB kind.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   start           begin/restart a load session (ignored while loading)
//   req_valid/ready handshake; req_kind/rs/rt/rd/imm/target/last request
//   imem_we/addr/wd instruction-memory write port (registered)
//   count           words written this session
//   full            2^DEPTH_LOG2 words written
//   done            session ended by req_last
//   err             sticky illegal-kind flag (cleared only by reset)
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting requests, req_ready high
// FULL   | memory filled before req_last, waiting for start
// DONE   | req_last accepted, waiting for start
module instr_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_kind,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_rd,
  input  logic [15:0]           req_imm,
  input  logic [25:0]           req_target,
  input  logic                  req_last,
  output logic                  imem_we,
  output logic [DEPTH_LOG2-1:0] imem_addr,
  output logic [31:0]           imem_wd,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DONE} state_t;

  localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                state, state_nx;
  logic                  enter_load;
  logic                  xfer;
  logic                  pk_legal;
  logic [31:0]           pk_word;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2:0]   count_inc;
  logic                  hit_full;

  instr_pack u_pack (
    .kind   (req_kind),
    .rs     (req_rs),
    .rt     (req_rt),
    .rd     (req_rd),
    .imm    (req_imm),
    .target (req_target),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  assign req_ready = (state == S_LOAD);
  assign done      = (state == S_DONE);
  assign xfer      = req_valid && req_ready;
  assign count_inc = count + 1'b1;
  // Only a written word can fill memory; illegal transfers leave count alone.
  assign hit_full  = xfer && pk_legal && (count_inc == DEPTH_WORDS);

  always_comb begin
    state_nx   = state;
    enter_load = 1'b0;
    case (state)
      S_IDLE, S_FULL, S_DONE: begin
        if (start) begin
          state_nx   = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        // req_last wins over full; full still gets flagged via hit_full.
        if (xfer && req_last) state_nx = S_DONE;
        else if (hit_full)    state_nx = S_FULL;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 32'd0;
      wr_addr   <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (enter_load) begin
        wr_addr <= '0;
        count   <= '0;
        full    <= 1'b0;
      end
      if (xfer) begin
        if (pk_legal) begin
          imem_we   <= 1'b1;
          imem_addr <= wr_addr;
          imem_wd   <= pk_word;
          wr_addr   <= wr_addr + 1'b1;
          count     <= count_inc;
        end else begin
          err <= 1'b1;
        end
      end
      if (hit_full) full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int DL = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [4:0]    req_rs, req_rt, req_rd;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          req_last;
  logic          imem_we;
  logic [DL-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [DL:0]   count;
  logic          full;
  logic          done;
  logic          err;

  instr_encoder #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .req_last   (req_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .count      (count),
    .full       (full),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DL-1:0] addr;
    logic [31:0]   wd;
  } wr_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DL-1:0] exp_addr = '0;
  int            exp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h wd=%0h required=none", imem_addr, imem_wd);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.addr));
        chk("write_data", 64'(imem_wd), 64'(e.wd));
      end
    end
  end

  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic wr, input logic [31:0] word);
    int n;
    n = 0;
    req_kind   = kind;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_imm    = imm;
    req_target = tgt;
    req_last   = last;
    req_valid  = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%0b required=1", req_ready);
      req_valid = 1'b0;
      req_last  = 1'b0;
    end else begin
      if (wr) begin
        exp_q.push_back('{addr: exp_addr, wd: word});
        exp_addr++;
        exp_count++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_last  = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_addr  = '0;
    exp_count = 0;
    chk("start_count", 64'(count), 64'd0);
    chk("start_ready", 64'(req_ready), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_full", 64'(full), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wd"}, 64'(imem_wd), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; req_valid = 1'b0; req_kind = 4'd0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0; req_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Session 1: ADD then J with last.
    do_start();
    send(K_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
    chk("add_we", 64'(imem_we), 64'd1);
    chk("add_count", 64'(count), 64'd1);
    send(K_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 1'b1, 32'h08000010);
    chk("j_done", 64'(done), 64'd1);
    chk("j_ready", 64'(req_ready), 64'd0);
    chk("j_count", 64'(count), 64'(exp_count));
    chk("j_full", 64'(full), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_hold", 64'(done), 64'd1);

    // Session 2: back-to-back I-type, LB, illegal kind, AND with last.
    do_start();
    send(K_LW, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h8C080004);
    send(K_BNE, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h1422FFFF);
    chk("bne_count", 64'(count), 64'd2);
`ifdef MIPS_LB_EN
    send(K_LB, 5'd2, 5'd5, 5'd0, 16'h0001, 26'h0, 1'b0, 1'b1, 32'h80450001);
    chk("lb_err", 64'(err), 64'd0);
`else
    send(K_LB, 5'd2, 5'd5, 5'd0, 16'h0001, 26'h0, 1'b0, 1'b0, 32'h0);
    chk("lb_err", 64'(err), 64'd1);
`endif
    chk("lb_count", 64'(count), 64'(exp_count));
    send(4'd13, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0);
    chk("illegal_err", 64'(err), 64'd1);
    chk("illegal_count", 64'(count), 64'(exp_count));
    send(K_AND, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00853024);
    chk("and_done", 64'(done), 64'd1);
    chk("and_count", 64'(count), 64'(exp_count));
`ifdef MIPS_LB_EN
    chk("and_full", 64'(full), 64'd1);
`else
    chk("and_full", 64'(full), 64'd0);
`endif

    // Session 3: fill memory, fifth request must be refused.
    do_start();
    chk("err_retained", 64'(err), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      send(K_ADDI, 5'd0, 5'(k), 5'd0, 16'(k), 26'h0, 1'b0, 1'b1,
           32'h20000000 | (32'(k) << 16) | 32'(k));
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(req_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_done", 64'(done), 64'd0);
    req_kind = K_ADDI; req_rt = 5'd5; req_imm = 16'd5; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fifth_ready", 64'(req_ready), 64'd0);
    chk("fifth_count", 64'(count), 64'd4);
    req_valid = 1'b0;

    // Session 4: restart, then reset right after a transfer.
    do_start();
    send(K_SUB, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00E84822);
    chk("sub_we", 64'(imem_we), 64'd1);
    req_kind = K_OR; req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd1; req_valid = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_reset_vals("midrst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(req_ready), 64'd0);
    chk("post_rst_we", 64'(imem_we), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that is the encoding counterpart of the main control decoder. It accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake and packs each into a 32-bit MIPS machine word using the same opcode and funct assignments the decoder consumes. It writes the words sequentially into instruction memory. It sits between the test/boot sequencer and the instruction memory write port, ahead of the pipelined core.

## Interface
Parameters:
- DEPTH_LOG2, 6: log2 of instruction-memory words the loader may fill.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin or restart a load session.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_kind  in  4  instruction kind (instr_kind_t).
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  I-type immediate.
- req_target  in  26  J-type target.
- req_last  in  1  final instruction of the session.
- imem_we  out  1  write strobe.
- imem_addr  out  DEPTH_LOG2  word address.
- imem_wd  out  32  encoded word.
- count  out  DEPTH_LOG2+1  words written this session.
- full  out  1  DEPTH words written.
- done  out  1  session finished.
- err  out  1  sticky: an illegal kind was received.

## Operation
- Kinds and encodings:
  - ADD=0 (funct 0x20), SUB=1 (0x22), AND=2 (0x24), OR=3 (0x25), SLT=4 (0x2A): {000000, rs, rt, rd, 00000, funct}.
  - LW=5 (0x23), SW=6 (0x2B), BEQ=7 (0x04), BNE=8 (0x05), ADDI=9 (0x08), LB=11 (0x20): {op, rs, rt, imm}.
  - J=10 (0x02): {op, target}.
  - 12–15: illegal.
- Unused fields are ignored, never OR-ed in.
- FSM states IDLE, LOAD, FULL, DONE. Reset enters IDLE.
  - IDLE --start--> LOAD.
  - LOAD --accepted req_last--> DONE.
  - LOAD --count reaches 2^DEPTH_LOG2--> FULL.
  - FULL/DONE --start--> LOAD.
  - start in LOAD is ignored.
- Entering LOAD clears count and the write address. err is not cleared by start.
- req_ready = (state == LOAD). A transfer occurs when req_valid && req_ready.
- Legal transfer: the word is written at the current address, then the address and count increment.
- Illegal transfer:
  - Request is consumed and nothing is written.
  - err is set; count and address hold.
  - req_last still takes effect.
- Simultaneous last and reaching full: DONE takes precedence, and full is still asserted.

## Timing
- Reset values: req_ready=0, imem_we=0, imem_addr=0, imem_wd=0, count=0, full=0, done=0, err=0.
- Write latency is one cycle. A transfer at edge N gives imem_we=1 with imem_addr/imem_wd valid for the cycle after edge N.
- imem_we is high for exactly one cycle per legal transfer. Back-to-back transfers give back-to-back writes.
- count updates on the same edge as imem_we rises.
- full and done are registered. They are high from the cycle after the causing transfer, and remain high until start or reset.
- req_ready drops the cycle after the causing transfer, so no transfer is lost or duplicated.
- Reset asserted mid-session: the pending write is dropped (imem_we=0 the next cycle) and all outputs return to reset values.

## Configuration
- MIPS_LB_EN defined: kind 11 (LB) is legal and encodes opcode 0x20.
- MIPS_LB_EN undefined: kind 11 is treated as illegal (sets err, no write). This matches a core built without load-byte support.

## Structure
- Shared package mips_pkg holds:
  - instr_kind_t enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_LB);
  - funct constants.
- The main decoder uses the same constants.
- Sub-module instr_pack: combinational packer taking kind and fields, producing word[31:0] and legal. The MIPS_LB_EN check lives in instr_pack.
- FSM, counters and output registers live in instr_encoder.

## Test plan
- start, then ADD rs=1 rt=2 rd=3 -> next cycle imem_we=1, addr=0, wd=0x00221820, count=1.
- Back-to-back LW rs=0 rt=8 imm=4, then BNE rs=1 rt=2 imm=0xFFFF -> consecutive writes 0x8C080004 @0, 0x1422FFFF @1.
- J target=0x10 with req_last=1 -> wd=0x08000010, then done=1 and req_ready=0 one cycle after the transfer.
- LB rs=2 rt=5 imm=1:
  - with MIPS_LB_EN -> 0x80450001;
  - without -> no write, err=1, count unchanged.
- DEPTH_LOG2=2 with 5 valid requests -> 4 writes, full=1, fifth request not accepted. start -> count=0, addr=0, err retained.
- Reset mid-stream with a transfer on the preceding edge -> imem_we=0 next cycle, all outputs at reset values, state IDLE.
